if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have pc_write_i  input  1  PC advance enable from hazard detection; 0 = hold PC.
REQ-005 SHALL have if_id_write_i  input  1  IF/ID register write enable from hazard detection; 0 = hold IF/ID.
REQ-006 SHALL have branch_taken_i  input  1  redirect request from ID/EX.
REQ-007 SHALL have branch_target_i  input  32  redirect PC.
REQ-008 SHALL have imem_req_o  output  1  instruction fetch request.
REQ-009 SHALL have imem_addr_o  output  32  fetch address; always equals pc_o.
REQ-010 SHALL have imem_ack_i  input  1  data valid; counted only in a cycle with imem_req_o=1.
REQ-011 SHALL have imem_data_i  input  32  instruction word for imem_addr_o, valid with imem_ack_i.
REQ-012 SHALL have pc_o  output  32  current fetch PC.
REQ-013 SHALL have id_pc4_o  output  32  IF/ID PC+4 of held instruction.
REQ-014 SHALL have id_instr_o  output  32  IF/ID instruction; 32'h0 when bubble.
REQ-015 SHALL have id_valid_o  output  1  IF/ID holds a real instruction.

Function
REQ-016 SHALL implement FSM states FETCH (imem_req_o=1) and HOLD (imem_req_o=0, instruction parked in a 32-bit fetch buffer with its PC+4).
REQ-017 SHALL define "advance" as pc_write_i=1 and if_id_write_i=1 in the same cycle.
REQ-018 In FETCH with imem_ack_i=1 and advance: SHALL load IF/ID from imem_data_i with pc_o+4, id_valid_o=1, PC <= pc_o+4, remain FETCH; sustained throughput one instruction per cycle.
REQ-019 In FETCH with imem_ack_i=1 and no advance: SHALL capture data into fetch buffer, PC unchanged, go HOLD.
REQ-020 In FETCH with imem_ack_i=0: PC SHALL hold; if if_id_write_i=1, IF/ID SHALL load a bubble (id_valid_o=0, id_instr_o=0); if 0, IF/ID holds.
REQ-021 In HOLD with advance: SHALL load IF/ID from fetch buffer, PC <= pc_o+4, go FETCH; otherwise all state holds.
REQ-022 if_id_write_i=0 SHALL freeze id_pc4_o, id_instr_o, id_valid_o regardless of other inputs except branch_taken_i and reset.
REQ-023 branch_taken_i=1 SHALL, next edge and in any state: PC <= branch_target_i, discard fetch buffer and any same-cycle ack, IF/ID <= bubble, state <= FETCH; overrides pc_write_i and if_id_write_i.
REQ-024 PC arithmetic SHALL be 32-bit unsigned, wrapping 32'hFFFF_FFFC+4 to 32'h0000_0000; branch_target_i low two bits SHALL be forced to 0.
REQ-025 imem_ack_i with imem_req_o=0 SHALL be ignored.

Reset
REQ-026 On rst_i=1 SHALL immediately set: PC=RESET_PC, state=FETCH, fetch buffer cleared, id_pc4_o=0, id_instr_o=0, id_valid_o=0; imem_req_o=1 after rst_i deasserts.
REQ-027 Reset mid-HOLD or mid-stall SHALL discard the buffered instruction; no IF/ID write occurs in the release cycle unless ack arrives.

Structure
REQ-028 SHALL place state encoding (FETCH=1'b0, HOLD=1'b1), NOP word 32'h0 and instruction width 32 in the shared CPU package.
REQ-029 SHALL instantiate one sub-module, if_id_reg (IF/ID pipeline register with write enable and flush); PC logic and FSM stay in if_stage.

Verification
REQ-030 Reset then ack every cycle, advance=1 -> pc_o 0,4,8,12; id_pc4_o 4,8,12 one cycle behind; id_valid_o=1 from cycle 2.
REQ-031 Hazard stall: pc_write_i=if_id_write_i=0 for 1 cycle at pc_o=8 with ack -> HOLD, imem_req_o=0, IF/ID frozen at pc4=8; next advance loads instr@8, pc_o=12.
REQ-032 imem_ack_i=0 for 3 cycles at pc_o=16, advance=1 -> pc_o stays 16, three bubbles (id_valid_o=0, id_instr_o=0), then instr@16 with id_pc4_o=20.
REQ-033 branch_taken_i=1, target 32'h0000_0103, while in HOLD with pc_write_i=0 -> pc_o=32'h100, FETCH, id_valid_o=0, buffered instruction never appears.
REQ-034 Wrap: RESET_PC=32'hFFFF_FFFC, ack, advance -> pc_o=0, id_pc4_o=0.
REQ-035 rst_i asserted asynchronously mid-HOLD -> outputs reset without clock edge; ack in same cycle as release is ignored until imem_req_o=1.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared CPU definitions used by the fetch stage and its IF/ID register.
package if_stage_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: write enable loads a fetched instruction,
// flush loads a bubble and takes priority over the write enable.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               flush,
  input  logic [31:0]        pc4_d,
  input  logic [INSTR_W-1:0] instr_d,
  output logic [31:0]        pc4_q,
  output logic [INSTR_W-1:0] instr_q,
  output logic               valid_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc4_q   <= 32'h0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (flush) begin
      pc4_q   <= 32'h0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (we) begin
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, FETCH/HOLD fetch FSM with a one-entry
// fetch buffer, branch redirect, and the IF/ID pipeline register.
//
// state | meaning
// FETCH | request outstanding at pc_o; ack with advance moves one instruction
// HOLD  | fetched word parked in buffer, waiting for the hazard stall to lift
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pc_write_i,
  input  logic               if_id_write_i,
  input  logic               branch_taken_i,
  input  logic [31:0]        branch_target_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [31:0]        pc_o,
  output logic [31:0]        id_pc4_o,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic               id_valid_o
);

  if_state_e          state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
  logic [31:0]        buf_pc4_q, buf_pc4_d;
  logic               id_we, id_flush;
  logic [INSTR_W-1:0] id_instr_d;
  logic [31:0]        id_pc4_d;
  logic               advance;
  logic [31:0]        pc_plus4;

  assign advance  = pc_write_i & if_id_write_i;
  assign pc_plus4 = pc_q + 32'd4;

  // Request is masked while reset is held so an ack in that window is ignored.
  assign imem_req_o  = (state_q == FETCH) & ~rst_i;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      buf_instr_q <= NOP_WORD;
      buf_pc4_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    id_we       = 1'b0;
    id_flush    = 1'b0;
    id_instr_d  = imem_data_i;
    id_pc4_d    = pc_plus4;

    if (branch_taken_i) begin
      pc_d        = branch_target_i & ~32'h3;
      state_d     = FETCH;
      buf_instr_d = NOP_WORD;
      buf_pc4_d   = 32'h0;
      id_flush    = 1'b1;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ack_i) begin
            if (advance) begin
              id_we = 1'b1;
              pc_d  = pc_plus4;
            end else begin
              buf_instr_d = imem_data_i;
              buf_pc4_d   = pc_plus4;
              state_d     = HOLD;
            end
          end else if (if_id_write_i) begin
            id_flush = 1'b1;
          end
        end
        HOLD: begin
          if (advance) begin
            id_we      = 1'b1;
            id_instr_d = buf_instr_q;
            id_pc4_d   = buf_pc4_q;
            pc_d       = pc_plus4;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk_i),
    .rst     (rst_i),
    .we      (id_we),
    .flush   (id_flush),
    .pc4_d   (id_pc4_d),
    .instr_d (id_instr_d),
    .pc4_q   (id_pc4_o),
    .instr_q (id_instr_o),
    .valid_q (id_valid_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stalls, ack gaps, branch,
// PC wrap and asynchronous reset. Memory returns {16'hC0DE, addr[15:0]}.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, pw, iw, br, ack;
  logic [31:0] br_tgt;
  logic        req;
  logic [31:0] addr, data, pc, id_pc4, id_instr;
  logic        id_valid;

  logic        rst_w, ack_w;
  logic        req_w, id_valid_w;
  logic [31:0] addr_w, data_w, pc_w, id_pc4_w, id_instr_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign data   = {16'hC0DE, addr[15:0]};
  assign data_w = {16'hC0DE, addr_w[15:0]};

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .pc_write_i(pw), .if_id_write_i(iw),
    .branch_taken_i(br), .branch_target_i(br_tgt),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .pc_o(pc), .id_pc4_o(id_pc4), .id_instr_o(id_instr), .id_valid_o(id_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst_w), .pc_write_i(1'b1), .if_id_write_i(1'b1),
    .branch_taken_i(1'b0), .branch_target_i(32'h0),
    .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_ack_i(ack_w), .imem_data_i(data_w),
    .pc_o(pc_w), .id_pc4_o(id_pc4_w), .id_instr_o(id_instr_w), .id_valid_o(id_valid_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string name, input logic [31:0] e_pc, input logic e_req,
                          input logic [31:0] e_pc4, input logic [31:0] e_instr, input logic e_valid);
    n_checks++;
    if (pc !== e_pc || req !== e_req || id_pc4 !== e_pc4 || id_instr !== e_instr ||
        id_valid !== e_valid || addr !== e_pc) begin
      n_fail++;
      $display("FAIL %s: got pc=%h addr=%h req=%b pc4=%h instr=%h valid=%b, want pc=%h req=%b pc4=%h instr=%h valid=%b",
               name, pc, addr, req, id_pc4, id_instr, id_valid, e_pc, e_req, e_pc4, e_instr, e_valid);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; pw = 1'b1; iw = 1'b1; br = 1'b0; ack = 1'b0; br_tgt = 32'h0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pw = 1'b1; iw = 1'b1; br = 1'b0; ack = 1'b1; br_tgt = 32'h0;
    rst_w = 1'b1; ack_w = 1'b1;
    #2;
    chk_main("reset_held", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk_main("reset_held_edge", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    chk_main("reset_release", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] exp_in [3] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008};
    do_reset();
    ack = 1'b1; pw = 1'b1; iw = 1'b1;
    chk_main("seq_c0", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_main($sformatf("seq_c%0d", i + 1), exp_pc[i], 1'b1, exp_pc[i], exp_in[i], 1'b1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    ack = 1'b1; pw = 1'b1; iw = 1'b1;
    step(); step();
    chk_main("stall_pre", 32'h8, 1'b1, 32'h8, 32'hC0DE_0004, 1'b1);
    pw = 1'b0; iw = 1'b0;
    step();
    chk_main("stall_hold", 32'h8, 1'b0, 32'h8, 32'hC0DE_0004, 1'b1);
    step();
    chk_main("stall_hold2", 32'h8, 1'b0, 32'h8, 32'hC0DE_0004, 1'b1);
    ack = 1'b0; pw = 1'b1; iw = 1'b1;
    step();
    chk_main("stall_release", 32'hC, 1'b1, 32'hC, 32'hC0DE_0008, 1'b1);
  endtask

  task automatic test_ack_gap();
    ack = 1'b1; pw = 1'b1; iw = 1'b1;
    step();
    chk_main("gap_pre", 32'h10, 1'b1, 32'h10, 32'hC0DE_000C, 1'b1);
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_main($sformatf("gap_bubble%0d", i), 32'h10, 1'b1, 32'h0, 32'h0, 1'b0);
    end
    ack = 1'b1;
    step();
    chk_main("gap_resume", 32'h14, 1'b1, 32'h14, 32'hC0DE_0010, 1'b1);
  endtask

  task automatic test_freeze();
    ack = 1'b0; pw = 1'b1; iw = 1'b0;
    step();
    chk_main("freeze_noack", 32'h14, 1'b1, 32'h14, 32'hC0DE_0010, 1'b1);
    ack = 1'b1; pw = 1'b1; iw = 1'b0;
    step();
    chk_main("freeze_ack_to_hold", 32'h14, 1'b0, 32'h14, 32'hC0DE_0010, 1'b1);
    ack = 1'b0; pw = 1'b1; iw = 1'b1;
    step();
    chk_main("freeze_release", 32'h18, 1'b1, 32'h18, 32'hC0DE_0014, 1'b1);
  endtask

  task automatic test_branch();
    ack = 1'b1; pw = 1'b0; iw = 1'b1;
    step();
    chk_main("br_to_hold", 32'h18, 1'b0, 32'h18, 32'hC0DE_0014, 1'b1);
    br = 1'b1; br_tgt = 32'h0000_0103; pw = 1'b0; iw = 1'b1;
    step();
    chk_main("br_redirect", 32'h100, 1'b1, 32'h0, 32'h0, 1'b0);
    br = 1'b0; ack = 1'b1; pw = 1'b1; iw = 1'b1;
    step();
    chk_main("br_first", 32'h104, 1'b1, 32'h104, 32'hC0DE_0100, 1'b1);
    br = 1'b1; br_tgt = 32'h0000_0042; ack = 1'b1; pw = 1'b1; iw = 1'b0;
    step();
    chk_main("br_over_ack", 32'h40, 1'b1, 32'h0, 32'h0, 1'b0);
    br = 1'b0;
  endtask

  task automatic test_wrap();
    rst_w = 1'b0;
    #1;
    n_checks++;
    if (pc_w !== 32'hFFFF_FFFC || req_w !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_reset: got pc=%h req=%b, want pc=fffffffc req=1", pc_w, req_w);
    end
    step();
    n_checks++;
    if (pc_w !== 32'h0 || id_pc4_w !== 32'h0 || id_instr_w !== 32'hC0DE_FFFC || id_valid_w !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_advance: got pc=%h pc4=%h instr=%h valid=%b, want pc=0 pc4=0 instr=c0defffc valid=1",
               pc_w, id_pc4_w, id_instr_w, id_valid_w);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ack = 1'b1; pw = 1'b1; iw = 1'b1;
    step();
    pw = 1'b0; iw = 1'b0;
    step();
    chk_main("ar_hold", 32'h4, 1'b0, 32'h4, 32'hC0DE_0000, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_main("ar_immediate", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    pw = 1'b1; iw = 1'b1; ack = 1'b1;
    step();
    chk_main("ar_ack_in_reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0; ack = 1'b0; iw = 1'b0;
    #1;
    chk_main("ar_release", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    step();
    chk_main("ar_no_stale", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    ack = 1'b1; iw = 1'b1;
    step();
    chk_main("ar_first", 32'h4, 1'b1, 32'h4, 32'hC0DE_0000, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_ack_gap();
    test_freeze();
    test_branch();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
